// File: rtl/trivial_rv_core_if.sv
// trivial_rv_core_if: instruction, write-back and debug-read signals of the execute core
interface trivial_rv_core_if #(parameter int XLEN = 32);
    logic            instr_valid;
    logic [31:0]     instruction;
    logic [4:0]      dbg_idx;
    logic [XLEN-1:0] dbg_data;
    logic            wb_en;
    logic [4:0]      wb_idx;
    logic [XLEN-1:0] wb_data;
    logic            illegal;
    modport master (output instr_valid, instruction, dbg_idx,
                    input  dbg_data, wb_en, wb_idx, wb_data, illegal);
    modport slave  (input  instr_valid, instruction, dbg_idx,
                    output dbg_data, wb_en, wb_idx, wb_data, illegal);
endinterface

// File: rtl/trivial_rv_core.sv
// trivial_rv_core: single-cycle RV32I ALU datapath with a 32x32 register file
module trivial_rv_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    trivial_rv_core_if.slave   bus
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      op;
    logic            mod, is_op, is_imm, legal, neg;
    logic [XLEN-1:0] imm, a, b, res;
    logic [4:0]      sh;

    assign opcode = bus.instruction[6:0];
    assign rd     = bus.instruction[11:7];
    assign op     = bus.instruction[14:12];
    assign rs1    = bus.instruction[19:15];
    assign rs2    = bus.instruction[24:20];
    assign funct7 = bus.instruction[31:25];
    assign mod    = funct7[5];
    assign imm    = {{(XLEN-12){bus.instruction[31]}}, bus.instruction[31:20]};

    always_comb begin
        is_op  = opcode == 7'b0110011;
        is_imm = opcode == 7'b0010011;
        legal  = is_op ? (funct7 == 7'b0000000 || (funct7 == 7'b0100000 && (op == 3'b000 || op == 3'b101)))
               : is_imm ? (op == 3'b001 ? funct7 == 7'b0000000
                         : op == 3'b101 ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1)
               : 1'b0;
        neg    = is_op && op == 3'b000 && mod;
        a      = rs1 == 5'd0 ? '0 : regs_q[rs1];
        b      = is_imm ? imm : (rs2 == 5'd0 ? '0 : regs_q[rs2]);
        sh     = b[4:0];
    end

    always_comb begin
        res = '0;
        case (op)
            3'b000: res = neg ? a - b : a + b;
            3'b001: res = a << sh;
            3'b010: res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'b011: res = {{(XLEN-1){1'b0}}, a < b};
            3'b100: res = a ^ b;
            3'b101: res = mod ? XLEN'($signed(a) >>> sh) : a >> sh;
            3'b110: res = a | b;
            default: res = a & b;
        endcase
    end

    assign bus.illegal  = bus.instr_valid & ~legal;
    assign bus.wb_en    = bus.instr_valid & legal & (rd != 5'd0);
    assign bus.wb_idx   = rd;
    assign bus.wb_data  = res;
    assign bus.dbg_data = bus.dbg_idx == 5'd0 ? '0 : regs_q[bus.dbg_idx];

    // x0 never takes a write because wb_en already excludes rd==0
    always_comb begin
        for (int i = 0; i < NREGS; i++)
            regs_d[i] = (bus.wb_en && rd == 5'(i)) ? res : regs_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        else
            regs_q <= regs_d;
    end
endmodule

// File: tb/tb_trivial_rv_core.sv
// tb_trivial_rv_core: directed-vector bench for the single-cycle RV32I execute core
module tb_trivial_rv_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    trivial_rv_core_if bus ();
    trivial_rv_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic v = 1'b1);
        @(negedge clk);
        bus.instr_valid = v;
        bus.instruction = ins;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic dbg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        bus.dbg_idx = idx;
        #1;
        check(tag, bus.dbg_data, exp);
    endtask

    task automatic alu(input string tag, input logic [31:0] ins, input logic [4:0] rd, input logic [31:0] exp);
        issue(ins);
        check({tag, "_wb_en"}, 32'(bus.wb_en), 32'd1);
        check({tag, "_wb_idx"}, 32'(bus.wb_idx), 32'(rd));
        check({tag, "_wb_data"}, bus.wb_data, exp);
        step();
        dbg({tag, "_reg"}, rd, exp);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instruction = 32'h0;
        bus.dbg_idx = 5'd0;
        #12;
        for (int i = 0; i < 32; i++) dbg("rst_sweep", 5'(i), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        alu("addi_x1", 32'h00500093, 5'd1, 32'd5);
        alu("add_x2", 32'h00108133, 5'd2, 32'd10);
        alu("sub_x3", 32'h401001B3, 5'd3, 32'hFFFFFFFB);
        alu("srai_x4", 32'h4011D213, 5'd4, 32'hFFFFFFFD);
        alu("srli_x4", 32'h0011D213, 5'd4, 32'h7FFFFFFD);
        alu("slt", 32'h0011A2B3, 5'd5, 32'd1);
        alu("sltu_lt", 32'h0030B2B3, 5'd5, 32'd1);
        alu("sltu_ge", 32'h0011B2B3, 5'd5, 32'd0);

        issue(32'h00700013);
        check("addi_x0_wb_en", 32'(bus.wb_en), 32'd0);
        check("addi_x0_illegal", 32'(bus.illegal), 32'd0);
        step();
        dbg("x0_zero", 5'd0, 32'h0);

        alu("addi_x6", 32'hFFF00313, 5'd6, 32'hFFFFFFFF);
        alu("andi", 32'h0F037393, 5'd7, 32'h000000F0);
        alu("ori", 32'h0F036393, 5'd7, 32'hFFFFFFFF);
        alu("xori", 32'h0F034393, 5'd7, 32'hFFFFFF0F);

        issue(32'h00208010);
        check("bad_op_illegal", 32'(bus.illegal), 32'd1);
        check("bad_op_wb_en", 32'(bus.wb_en), 32'd0);
        step();
        dbg("bad_op_x1", 5'd1, 32'd5);
        dbg("bad_op_x7", 5'd7, 32'hFFFFFF0F);
        issue(32'h00208010, 1'b0);
        check("bad_op_novalid", 32'(bus.illegal), 32'd0);
        check("novalid_wb_en", 32'(bus.wb_en), 32'd0);
        step();

        issue(32'h40209133);
        check("sll_mod_illegal", 32'(bus.illegal), 32'd1);
        step();
        dbg("sll_mod_x2", 5'd2, 32'd10);

        issue(32'h001080B3);
        check("hazard_wb_data", bus.wb_data, 32'd10);
        dbg("hazard_old", 5'd1, 32'd5);
        step();
        dbg("hazard_new", 5'd1, 32'd10);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        dbg("midrst_x1", 5'd1, 32'h0);
        dbg("midrst_x2", 5'd2, 32'h0);
        dbg("midrst_x6", 5'd6, 32'h0);
        dbg("midrst_x7", 5'd7, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trivial_rv_core.md
Name: trivial_rv_core

Overview:
- Single-cycle RV32I integer datapath: instruction decoder, 32x32 general-purpose register file and ALU, executing one register-register or register-immediate ALU instruction per clock.
- Decode, register read and ALU evaluation are combinational; write-back occurs on the rising clock edge.
- The block is the execute core of the trivial CPU; fetch and memory stages are out of scope.

Parameters:
- XLEN, 32, data and register width.
- NREGS, 32, number of architectural registers; x0 is hard-wired zero.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction on `instruction` is executed this cycle
- instruction  input  32  RV32I instruction word
- dbg_idx  input  5  debug read-port register index
- dbg_data  output  32  combinational contents of register dbg_idx; always 0 for index 0
- wb_en  output  1  a register write happens at the next rising edge
- wb_idx  output  5  destination register (rd)
- wb_data  output  32  ALU result to be written
- illegal  output  1  instr_valid=1 with an unsupported encoding

Behaviour:
- Reset: rst_n=0 asynchronously clears all registers to 0. While rst_n=0, no write occurs. Outputs stay combinational: with all registers 0, they reflect the current instruction.
- Field decode:
  - opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
  - Internal signals: op=funct3, mod=funct7[5].
- Supported opcodes:
  - OP 0110011: use_imm=0. funct7 must be 0000000, or 0100000 only with funct3 000 or 101.
  - OP-IMM 0010011: use_imm=1, imm = sign-extended [31:20].
  - For funct3 001 (SLLI), funct7 must be 0000000.
  - For funct3 101, funct7 must be 0000000 (SRLI) or 0100000 (SRAI); shamt=[24:20].
- Any other opcode or funct7 combination: illegal=1 (only when instr_valid=1), wb_en=0, no state change.
- neg=1 only for OP with funct3=000 and mod=1 (SUB). mod on funct3=101 selects arithmetic shift.
- ALU operand A = x[rs1]. Operand B = imm if use_imm, else x[rs2]. Reads of x0 return 0.
- ALU operations by funct3:
  - 000 ADD (A+B) or SUB (A-B when neg), modulo 2^32.
  - 001 SLL by B[4:0].
  - 010 SLT, signed compare, result 1/0.
  - 011 SLTU, unsigned compare.
  - 100 XOR.
  - 101 SRL, or SRA when mod; shift by B[4:0].
  - 110 OR.
  - 111 AND.
- Write-back:
  - wb_en = instr_valid & ~illegal & (rd≠0); wb_idx = rd; wb_data = ALU result.
  - On the rising edge with wb_en=1, x[rd] <= wb_data. Latency: the result is visible on dbg_data and to the following instruction one cycle later.
  - Writes to x0 are discarded.
- Same-register hazards (rs1=rs2=rd): the read returns the old value in the current cycle; the new value is visible next cycle. No bypass is needed because execution is single-cycle.
- instr_valid=0: no write; illegal=0.

Test Plan:
- Reset then dbg_idx sweep 0..31 -> every dbg_data=0x00000000. Assert rst_n low mid-run after writes -> all registers read 0 immediately, without waiting for a clock edge.
- ADDI x1,x0,5 (0x00500093) -> wb_en=1, wb_idx=1, wb_data=5; after edge dbg x1=5. Then ADD x2,x1,x1 (0x00108133) -> x2=10.
- SUB x3,x0,x1 (0x401001B3) -> x3=0xFFFFFFFB. SRAI x4,x3,1 (0x4011D213) -> 0xFFFFFFFD. SRLI x4,x3,1 (0x0011D213) -> 0x7FFFFFFD.
- SLT x5,x3,x1 (0x0011A2B3) -> 1. SLTU x5,x1,x3 (0x0030B2B3) -> 1. SLTU x5,x3,x1 (0x0011B2B3) -> 0.
- ADDI x0,x0,7 (0x00700013) -> wb_en=0; x0 still reads 0. ADDI x6,x0,-1 (0xFFF00313) -> x6=0xFFFFFFFF; then ANDI/ORI/XORI against 0x0F0 give 0x0F0, 0xFFFFFFFF, 0xFFFFFF0F.
- Unsupported opcode 0x00208010 with instr_valid=1 -> illegal=1, wb_en=0, register file unchanged. Same word with instr_valid=0 -> illegal=0.
